// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN activation-memory arbiter.
//   arb_state_t  : arbiter FSM states
//   NBANK/WORD_W : activation memory geometry (16 banks x 128 words)
//   ADDR_W/ACT_W : host address width {word, bank} and activation width
//   bank_onehot  : bank index -> 16-bit bank write-enable vector
package bnn_pkg;

  localparam int unsigned NBANK  = 16;
  localparam int unsigned BANK_W = 4;
  localparam int unsigned WORD_W = 7;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned ACT_W  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StHwr,
    StHrd,
    StLaunch,
    StWaitBusy,
    StRun
  } arb_state_t;

  function automatic logic [NBANK-1:0] bank_onehot(input logic [BANK_W-1:0] bank);
    logic [NBANK-1:0] oh;
    oh       = '0;
    oh[bank] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bnn_act_arbiter.sv
// Activation memory port arbiter for the BNN datapath.
// Shares the 16-bank activation memory between single host read/write ops
// (req/gnt handshake, rvalid pulse) and inference runs of the control unit,
// which it launches, supervises (busy timeout) and counts.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   host_*              : host op port (req/we/addr/wdata in; gnt/rvalid/rdata out)
//   start, done         : run request in, idle-and-nothing-pending out
//   run_count, run_err  : completed runs (wrapping), sticky busy-timeout flag
//   ctrl_start/idle     : launch pulse to / idle status from the control unit
//   ctrl_addr_*/enb_wr  : control-side memory addresses and bank write enables
//   mem_*               : memory-side addresses, bank enables, write/read data
module bnn_act_arbiter
  import bnn_pkg::*;
#(
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned BUSY_TO = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          host_req,
  input  logic                          host_we,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [ACT_W-1:0]              host_wdata,
  output logic                          host_gnt,
  output logic                          host_rvalid,
  output logic [ACT_W-1:0]              host_rdata,
  input  logic                          start,
  output logic                          done,
  output logic [CNT_W-1:0]              run_count,
  output logic                          run_err,
  output logic                          ctrl_start,
  input  logic                          ctrl_idle,
  input  logic [WORD_W-1:0]             ctrl_addr_rd,
  input  logic [WORD_W-1:0]             ctrl_addr_wr,
  input  logic [NBANK-1:0]              ctrl_enb_wr,
  output logic [WORD_W-1:0]             mem_addr_rd,
  output logic [WORD_W-1:0]             mem_addr_wr,
  output logic [NBANK-1:0]              mem_enb_wr,
  output logic [ACT_W-1:0]              mem_wdata,
  input  logic [NBANK-1:0][ACT_W-1:0]   mem_rdata
);

  localparam int unsigned RdCntW   = $clog2(RD_LAT + 1);
  localparam int unsigned BusyCntW = $clog2(BUSY_TO + 1);

  arb_state_t          state_q, state_d;
  logic                start_pending_q, start_pending_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ACT_W-1:0]    wdata_q, wdata_d;
  logic [RdCntW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [BusyCntW-1:0] busy_cnt_q, busy_cnt_d;
  logic [ACT_W-1:0]    rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic [CNT_W-1:0]    run_count_q, run_count_d;
  logic                run_err_q, run_err_d;

  logic [BANK_W-1:0]   bank;
  logic [WORD_W-1:0]   word;
  logic                accept;
  logic                ctrl_owns;

  assign bank = addr_q[BANK_W-1:0];
  assign word = addr_q[ADDR_W-1:BANK_W];

  // Gated by rst so the grant drops the moment reset is asserted.
  assign host_gnt = rst && (state_q == StIdle) && !start_pending_q;
  assign accept   = host_req && host_gnt;
  assign done     = (state_q == StIdle) && !start_pending_q && !start;

  always_comb begin
    state_d         = state_q;
    // A start in any state is remembered; only LAUNCH consumes it.
    start_pending_d = start_pending_q || start;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rd_cnt_d        = rd_cnt_q;
    busy_cnt_d      = busy_cnt_q;
    rdata_d         = rdata_q;
    rvalid_d        = 1'b0;
    run_count_d     = run_count_q;
    run_err_d       = run_err_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d = host_addr;
          if (host_we) begin
            wdata_d = host_wdata;
            state_d = StHwr;
          end else begin
            rd_cnt_d = RdCntW'(RD_LAT);
            state_d  = StHrd;
          end
        end else if (start_pending_q || start) begin
          state_d = StLaunch;
        end
      end
      StHwr: state_d = StIdle;
      StHrd: begin
        if (rd_cnt_q == '0) begin
          rdata_d  = mem_rdata[bank];
          rvalid_d = 1'b1;
          state_d  = StIdle;
        end else begin
          rd_cnt_d = rd_cnt_q - RdCntW'(1);
        end
      end
      StLaunch: begin
        start_pending_d = start;
        busy_cnt_d      = '0;
        state_d         = StWaitBusy;
      end
      StWaitBusy: begin
        if (!ctrl_idle) begin
          state_d = StRun;
        end else if (busy_cnt_q == BusyCntW'(BUSY_TO - 1)) begin
          // Control never went busy: flag it and retire the run anyway.
          run_err_d   = 1'b1;
          run_count_d = run_count_q + CNT_W'(1);
          state_d     = StIdle;
        end else begin
          busy_cnt_d = busy_cnt_q + BusyCntW'(1);
        end
      end
      StRun: begin
        if (ctrl_idle) begin
          run_count_d = run_count_q + CNT_W'(1);
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      start_pending_q <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rd_cnt_q        <= '0;
      busy_cnt_q      <= '0;
      rdata_q         <= '0;
      rvalid_q        <= 1'b0;
      run_count_q     <= '0;
      run_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      start_pending_q <= start_pending_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rd_cnt_q        <= rd_cnt_d;
      busy_cnt_q      <= busy_cnt_d;
      rdata_q         <= rdata_d;
      rvalid_q        <= rvalid_d;
      run_count_q     <= run_count_d;
      run_err_q       <= run_err_d;
    end
  end

  assign ctrl_owns = (state_q == StWaitBusy) || (state_q == StRun);

  always_comb begin
    mem_addr_rd = word;
    mem_addr_wr = word;
    mem_enb_wr  = '0;
    mem_wdata   = wdata_q;
    if (ctrl_owns) begin
      mem_addr_rd = ctrl_addr_rd;
      mem_addr_wr = ctrl_addr_wr;
      mem_enb_wr  = ctrl_enb_wr;
    end else if (state_q == StHwr) begin
      mem_enb_wr = bank_onehot(bank);
    end
  end

  assign ctrl_start  = (state_q == StLaunch);
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_q;
  assign run_count   = run_count_q;
  assign run_err     = run_err_q;

endmodule

// File: tb/tb_bnn_act_arbiter.sv
// Directed self-checking bench for bnn_act_arbiter with a 2-cycle-latency
// banked activation memory model. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_bnn_act_arbiter;

  logic              clk;
  logic              rst;
  logic              host_req;
  logic              host_we;
  logic [10:0]       host_addr;
  logic [7:0]        host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [7:0]        host_rdata;
  logic              start;
  logic              done;
  logic [15:0]       run_count;
  logic              run_err;
  logic              ctrl_start;
  logic              ctrl_idle;
  logic [6:0]        ctrl_addr_rd;
  logic [6:0]        ctrl_addr_wr;
  logic [15:0]       ctrl_enb_wr;
  logic [6:0]        mem_addr_rd;
  logic [6:0]        mem_addr_wr;
  logic [15:0]       mem_enb_wr;
  logic [7:0]        mem_wdata;
  logic [15:0][7:0]  mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  bnn_act_arbiter #(
    .RD_LAT (2),
    .BUSY_TO(4),
    .CNT_W  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .start       (start),
    .done        (done),
    .run_count   (run_count),
    .run_err     (run_err),
    .ctrl_start  (ctrl_start),
    .ctrl_idle   (ctrl_idle),
    .ctrl_addr_rd(ctrl_addr_rd),
    .ctrl_addr_wr(ctrl_addr_wr),
    .ctrl_enb_wr (ctrl_enb_wr),
    .mem_addr_rd (mem_addr_rd),
    .mem_addr_wr (mem_addr_wr),
    .mem_enb_wr  (mem_enb_wr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous bank writes, read data 2 cycles after address.
  logic [7:0] mem [16][128];
  logic [6:0] rd_pipe0, rd_pipe1;

  always @(posedge clk) begin
    for (int b = 0; b < 16; b++) begin
      if (mem_enb_wr[b]) mem[b][mem_addr_wr] <= mem_wdata;
    end
    rd_pipe0 <= mem_addr_rd;
    rd_pipe1 <= rd_pipe0;
  end

  always_comb begin
    mem_rdata = '0;
    for (int b = 0; b < 16; b++) mem_rdata[b] = mem[b][rd_pipe1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int n_cstart;
  int n_done;
  int k;

  initial begin
    rst          = 1'b0;
    host_req     = 1'b0;
    host_we      = 1'b0;
    host_addr    = '0;
    host_wdata   = '0;
    start        = 1'b0;
    ctrl_idle    = 1'b1;
    ctrl_addr_rd = '0;
    ctrl_addr_wr = '0;
    ctrl_enb_wr  = '0;

    // Reset state
    cyc(2);
    check("rst_done", done, 1);
    check("rst_gnt", host_gnt, 0);
    check("rst_cnt", run_count, 0);
    check("rst_err", run_err, 0);
    check("rst_cstart", ctrl_start, 0);
    check("rst_enb", mem_enb_wr, 0);
    check("rst_rvalid", host_rvalid, 0);
    rst = 1'b1;
    #1;
    check("idle_gnt", host_gnt, 1);

    // Host write 0xA5 -> addr 0x123 (bank 3, word 0x12)
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h123; host_wdata = 8'hA5;
    #1;
    check("wr_gnt", host_gnt, 1);
    cyc(1);
    host_req = 1'b0;
    check("wr_enb", mem_enb_wr, 16'h0008);
    check("wr_addr", mem_addr_wr, 7'h12);
    check("wr_data", mem_wdata, 8'hA5);
    check("wr_busy_gnt", host_gnt, 0);
    cyc(1);
    check("wr_end_enb", mem_enb_wr, 0);
    check("wr_end_gnt", host_gnt, 1);

    // Host read of addr 0x123: rvalid 3 cycles after the accepting edge
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h123;
    cyc(1);
    host_req = 1'b0;
    check("rd_addr", mem_addr_rd, 7'h12);
    check("rd_rv_c1", host_rvalid, 0);
    check("rd_gnt", host_gnt, 0);
    cyc(1);
    check("rd_rv_c2", host_rvalid, 0);
    cyc(1);
    check("rd_rv_c3", host_rvalid, 0);
    cyc(1);
    check("rd_rv", host_rvalid, 1);
    check("rd_data", host_rdata, 8'hA5);
    cyc(1);
    check("rd_rv_pulse", host_rvalid, 0);
    check("rd_hold", host_rdata, 8'hA5);

    // Normal run: ctrl_idle falls 2 cycles after ctrl_start, busy for 50 cycles
    start = 1'b1;
    #1;
    check("run_done_fall", done, 0);
    cyc(1);
    start = 1'b0;
    check("run_cstart", ctrl_start, 1);
    check("run_launch_done", done, 0);
    cyc(1);
    check("run_cstart_off", ctrl_start, 0);
    ctrl_addr_rd = 7'h2A; ctrl_addr_wr = 7'h55; ctrl_enb_wr = 16'h8001; ctrl_idle = 1'b0;
    #1;
    check("pt_addr_rd", mem_addr_rd, 7'h2A);
    check("pt_addr_wr", mem_addr_wr, 7'h55);
    check("pt_enb", mem_enb_wr, 16'h8001);
    n_cstart = 0;
    n_done   = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (ctrl_start) n_cstart++;
      if (done) n_done++;
    end
    check("run_pt_hold", mem_addr_rd, 7'h2A);
    check("run_gnt", host_gnt, 0);
    ctrl_idle = 1'b1; ctrl_enb_wr = '0;
    cyc(1);
    check("run_extra_cstart", n_cstart, 0);
    check("run_done_low", n_done, 0);
    check("run_cnt", run_count, 1);
    check("run_done_back", done, 1);
    check("run_err_clear", run_err, 0);
    check("run_enb_off", mem_enb_wr, 0);

    // Read and start in the same IDLE cycle: read first, then launch
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h123; start = 1'b1;
    #1;
    check("same_gnt", host_gnt, 1);
    check("same_done", done, 0);
    cyc(1);
    start = 1'b0;
    check("same_hrd_gnt", host_gnt, 0);
    k = 0;
    while (!host_rvalid && k < 6) begin
      cyc(1);
      k++;
    end
    check("same_rv", host_rvalid, 1);
    check("same_rv_lat", k, 3);
    check("same_rdata", host_rdata, 8'hA5);
    check("same_pend_gnt", host_gnt, 0);
    check("same_pend_done", done, 0);
    cyc(1);
    check("same_launch", ctrl_start, 1);
    check("same_launch_gnt", host_gnt, 0);
    cyc(1);
    ctrl_idle = 1'b0;
    #1;
    check("same_wb_gnt", host_gnt, 0);
    cyc(3);
    check("same_run_gnt", host_gnt, 0);
    ctrl_idle = 1'b1;
    cyc(1);
    check("same_cnt", run_count, 2);
    check("same_gnt_back", host_gnt, 1);
    host_req = 1'b0;

    // Busy timeout: ctrl_idle never falls
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    cyc(3);
    check("to_err_pre", run_err, 0);
    check("to_gnt_pre", host_gnt, 0);
    cyc(1);
    check("to_err", run_err, 1);
    check("to_cnt", run_count, 3);
    check("to_gnt", host_gnt, 1);
    check("to_done", done, 1);

    // Reset asserted during RUN
    start = 1'b1;
    cyc(1);
    start = 1'b0; ctrl_idle = 1'b0;
    cyc(1);
    cyc(1);
    ctrl_enb_wr = 16'h00F0;
    #1;
    check("rr_run_enb", mem_enb_wr, 16'h00F0);
    check("rr_run_done", done, 0);
    rst = 1'b0;
    #1;
    check("rr_enb", mem_enb_wr, 0);
    check("rr_cnt", run_count, 0);
    check("rr_err", run_err, 0);
    check("rr_cstart", ctrl_start, 0);
    check("rr_gnt", host_gnt, 0);
    check("rr_done", done, 1);
    cyc(1);
    rst = 1'b1; ctrl_idle = 1'b1; ctrl_enb_wr = '0;
    #1;
    check("rr_post_done", done, 1);
    check("rr_post_cnt", run_count, 0);
    check("rr_post_gnt", host_gnt, 1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("rr_relaunch", ctrl_start, 1);
    cyc(1);
    ctrl_idle = 1'b0;
    cyc(1);
    cyc(2);
    ctrl_idle = 1'b1;
    cyc(1);
    check("rr_relaunch_cnt", run_count, 1);
    check("rr_relaunch_done", done, 1);

    // Three starts during RUN collapse into exactly one extra run
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    ctrl_idle = 1'b0;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    start = 1'b1;
    cyc(1);
    cyc(1);
    start = 1'b0;
    cyc(2);
    ctrl_idle = 1'b1;
    cyc(1);
    check("ms_cnt1", run_count, 2);
    check("ms_pend_done", done, 0);
    check("ms_pend_gnt", host_gnt, 0);
    cyc(1);
    check("ms_cstart", ctrl_start, 1);
    ctrl_idle = 1'b0;
    cyc(1);
    cyc(1);
    cyc(2);
    ctrl_idle = 1'b1;
    cyc(1);
    check("ms_cnt2", run_count, 3);
    check("ms_done", done, 1);
    n_cstart = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (ctrl_start) n_cstart++;
    end
    check("ms_no_more", n_cstart, 0);
    check("ms_cnt_final", run_count, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_act_arbiter.md
Name: bnn_act_arbiter

Overview:
- Owns the 16-bank activation memory port of the BNN datapath: 16 banks × 128 words × 8 bits, with bank = addr[3:0] and word = addr[10:4].
- Arbitrates between the host access port (single read/write ops with a req/gnt handshake) and an inference run driven by the control unit.
- Sequences the run: launches the control unit, waits for busy then idle, and counts completed inferences.
- Replaces ad-hoc idle-based muxing with explicit handshakes and ordering.

Parameters:
- RD_LAT, 2, cycles from activation read address to valid mem_rdata.
- BUSY_TO, 4, max cycles to wait for ctrl_idle to fall after launch.
- CNT_W, 16, width of run_count.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- host_req  in  1  host op request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  11  {word[6:0], bank[3:0]}.
- host_wdata  in  8  write data.
- host_gnt  out  1  op accepted when host_req & host_gnt.
- host_rvalid  out  1  one-cycle pulse, host_rdata valid.
- host_rdata  out  8  read data, held until next read.
- start  in  1  run request (pulse or level; sampled in any state).
- done  out  1  state == IDLE and no pending start.
- run_count  out  CNT_W  completed runs, wraps.
- run_err  out  1  sticky, set on busy timeout.
- ctrl_start  out  1  one-cycle launch pulse to control.
- ctrl_idle  in  1  control idle.
- ctrl_addr_rd, ctrl_addr_wr  in  7  control-side addresses.
- ctrl_enb_wr  in  16  control-side bank write enables.
- mem_addr_rd, mem_addr_wr  out  7  to datapath.
- mem_enb_wr  out  16  to datapath.
- mem_wdata  out  8  to datapath.
- mem_rdata  in  16×8  datapath bank outputs.

Behaviour:
- Reset (rst = 0, async): state IDLE, start_pending = 0, all outputs 0 except done = 1, run_count = 0, run_err = 0. Reset mid-run or mid-read aborts with no rvalid.
- States:
  - IDLE, HWR, HRD, LAUNCH, WAIT_BUSY, RUN.
  - IDLE: host_gnt = !start_pending (combinational). The host op wins over a same-cycle start; that start is latched into start_pending.
  - IDLE with accepted write: register addr and data, go to HWR.
  - IDLE with accepted read: register addr, go to HRD.
  - IDLE with start_pending or start and no accepted op: go to LAUNCH.
  - HWR (1 cycle): mem_addr_wr = word, mem_wdata = data, mem_enb_wr = one-hot(bank), then IDLE. Net rate is one write per 2 cycles.
  - HRD: mem_addr_rd = word, held for RD_LAT cycles. On the last cycle, capture mem_rdata[bank] into host_rdata and pulse host_rvalid on the next cycle, then IDLE. Read latency from accept edge to rvalid = RD_LAT+1 cycles.
  - LAUNCH (1 cycle): ctrl_start = 1, clear start_pending, go to WAIT_BUSY.
  - WAIT_BUSY: leave when ctrl_idle = 0 → RUN.
    - If ctrl_idle stays 1 for BUSY_TO cycles: set run_err, increment run_count, go to IDLE.
  - RUN: go to IDLE when ctrl_idle = 1 and increment run_count (wraps at 2^CNT_W). This exit rule is the same as the RUN rule below.
- start in any non-IDLE state sets start_pending; multiple starts collapse to one.
- Memory mux:
  - In WAIT_BUSY and RUN: mem_* = ctrl_* pass-through (combinational).
  - Else: host-side registered addresses.
  - mem_enb_wr = 0 outside HWR, WAIT_BUSY and RUN.
- host_gnt = 0 in all states except IDLE; host_req held by the host is granted on return to IDLE.
- done falls combinationally in the cycle start is sampled in IDLE.

Decomposition:
- Package bnn_pkg holds:
  - arb_state_t enum.
  - NBANK = 16, WORD_W = 7, ADDR_W = 11, ACT_W = 8.
  - Function bank_onehot(bank) returning a 16-bit one-hot.
- No sub-module; the RD_LAT countdown is an inline counter.

Test Plan:
- Host write 0xA5 to addr 0x123 then read addr 0x123 (RD_LAT = 2):
  - write cycle shows mem_enb_wr = 0x0008, mem_addr_wr = 0x12;
  - rvalid arrives 3 cycles after read accept with host_rdata = 0xA5.
- start pulse in IDLE, ctrl_idle falls 2 cycles after ctrl_start and rises 50 cycles later:
  - one ctrl_start pulse; done = 0 throughout;
  - ctrl_* passed through; run_count = 1 and done = 1 on return.
- host_req read and start in the same IDLE cycle:
  - read completes first, then LAUNCH;
  - host_gnt stays low during the run despite host_req held.
- ctrl_idle never falls after launch:
  - after 4 cycles run_err = 1, run_count increments, state IDLE, host_gnt = 1.
- rst low during RUN:
  - outputs zeroed immediately, done = 1 after release, run_count = 0;
  - a new start relaunches normally.
- Three starts during RUN → exactly one additional run; run_count advances by 2 total.
